lab3_cache_flush_ctrl: RTL and testbench



---
 rtl/lab3_cache_flush_ctrl_if.sv | 85 ++++++++
 rtl/lab3_cache_flush_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lab3_cache_flush_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_cache_flush_ctrl_if.sv
// ---------------------------------------------------------------------------
// lab3_cache_flush_ctrl_if
//
// Bundles every signal between the flush sequencer and its surroundings
// (cache controller, cache datapath, batch sender and memory response path).
//
//   master : the environment side (controller / datapath / sender / memory)
//   slave  : the flush sequencer itself
//
// Signal groups:
//   flush request/response : flush_req_val/rdy, flush_resp_val/rdy,
//                            flush_busy, flush_wb_count
//   datapath index control : index_mux_sel, idx_incr_mux_sel,
//                            index_incr_reg_en, read_way
//   dirty array            : is_dirty, dirty_wen, dirty_wdata
//   batch sender           : batch_send_istream_val/rdy, batch_send_rw,
//                            batch_send_addr_sel
//   memory write responses : mem_wr_ack
// ---------------------------------------------------------------------------
interface lab3_cache_flush_ctrl_if;
    logic       flush_req_val;
    logic       flush_req_rdy;
    logic       flush_resp_val;
    logic       flush_resp_rdy;
    logic       flush_busy;
    logic [6:0] flush_wb_count;

    logic       index_mux_sel;
    logic       idx_incr_mux_sel;
    logic       index_incr_reg_en;
    logic       read_way;

    logic       is_dirty;
    logic       dirty_wen;
    logic       dirty_wdata;

    logic       batch_send_istream_val;
    logic       batch_send_istream_rdy;
    logic       batch_send_rw;
    logic       batch_send_addr_sel;

    logic       mem_wr_ack;

    modport master (
        output flush_req_val,
        input  flush_req_rdy,
        input  flush_resp_val,
        output flush_resp_rdy,
        input  flush_busy,
        input  flush_wb_count,
        input  index_mux_sel,
        input  idx_incr_mux_sel,
        input  index_incr_reg_en,
        input  read_way,
        output is_dirty,
        input  dirty_wen,
        input  dirty_wdata,
        input  batch_send_istream_val,
        output batch_send_istream_rdy,
        input  batch_send_rw,
        input  batch_send_addr_sel,
        output mem_wr_ack
    );

    modport slave (
        input  flush_req_val,
        output flush_req_rdy,
        output flush_resp_val,
        input  flush_resp_rdy,
        output flush_busy,
        output flush_wb_count,
        output index_mux_sel,
        output idx_incr_mux_sel,
        output index_incr_reg_en,
        output read_way,
        input  is_dirty,
        output dirty_wen,
        output dirty_wdata,
        output batch_send_istream_val,
        input  batch_send_istream_rdy,
        output batch_send_rw,
        output batch_send_addr_sel,
        input  mem_wr_ack
    );
endinterface

// File: rtl/lab3_cache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// lab3_cache_flush_ctrl
//
// Flush sequencer for the 2-way set-associative write-back cache (32 sets,
// 2 ways, 16 words/line). On an accepted flush request it walks all 64 lines
// in order set 0..31, way 0 then way 1, hands every dirty line to the batch
// sender, clears its dirty bit, then waits until the sender is idle and all
// memory write acks are back before raising flush_resp_val.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : lab3_cache_flush_ctrl_if.slave (flush handshake, datapath index
//            control, dirty array, batch sender, memory write acks)
// ---------------------------------------------------------------------------
module lab3_cache_flush_ctrl (
    input  logic                         clk,
    input  logic                         reset,
    lab3_cache_flush_ctrl_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND,
        NEXT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [4:0]  LAST_SET      = 5'd31;
    localparam logic [10:0] WORDS_PER_LINE = 11'd16;

    state_t      state_q, state_d;
    logic [4:0]  set_q, set_d;
    logic        way_q, way_d;
    logic        first_q, first_d;
    logic [10:0] acks_q, acks_d;
    logic [6:0]  wb_q, wb_d;

    logic        send_fire;
    logic        ack_counted;

    logic        req_rdy;
    logic        resp_val;
    logic        idx_mux;
    logic        incr_mux;
    logic        incr_en;
    logic        way_out;
    logic        wen;
    logic        send_val;

    // The sender latches address and data on the val&rdy cycle.
    assign send_fire   = (state_q == SEND) && bus.batch_send_istream_rdy;
    // An ack with nothing outstanding is stray and must not wrap the counter.
    assign ack_counted = bus.mem_wr_ack && (acks_q != 11'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            set_q   <= 5'd0;
            way_q   <= 1'b0;
            first_q <= 1'b0;
            acks_q  <= 11'd0;
            wb_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            first_q <= first_d;
            acks_q  <= acks_d;
            wb_q    <= wb_d;
        end
    end

    // Outstanding write-ack counter: each sent line owes 16 response words.
    always_comb begin
        acks_d = acks_q;
        if (send_fire && ack_counted) begin
            acks_d = acks_q + WORDS_PER_LINE - 11'd1;
        end else if (send_fire) begin
            acks_d = acks_q + WORDS_PER_LINE;
        end else if (ack_counted) begin
            acks_d = acks_q - 11'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        set_d    = set_q;
        way_d    = way_q;
        first_d  = first_q;
        wb_d     = wb_q;

        req_rdy  = 1'b0;
        resp_val = 1'b0;
        idx_mux  = 1'b0;
        incr_mux = 1'b0;
        incr_en  = 1'b0;
        way_out  = 1'b0;
        wen      = 1'b0;
        send_val = 1'b0;

        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.flush_req_val) begin
                    set_d   = 5'd0;
                    way_d   = 1'b0;
                    first_d = 1'b1;
                    wb_d    = 7'd0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                // While first is set the datapath index register still holds
                // whatever the last access left there, so force set 0.
                idx_mux  = 1'b1;
                incr_mux = ~first_q;
                way_out  = way_q;
                state_d  = bus.is_dirty ? SEND : NEXT;
            end

            SEND: begin
                idx_mux  = 1'b1;
                incr_mux = ~first_q;
                way_out  = way_q;
                send_val = 1'b1;
                if (bus.batch_send_istream_rdy) begin
                    wen     = 1'b1;
                    wb_d    = wb_q + 7'd1;
                    state_d = NEXT;
                end
            end

            NEXT: begin
                if (!way_q) begin
                    way_d   = 1'b1;
                    state_d = CHECK;
                end else if (set_q == LAST_SET) begin
                    state_d = DRAIN;
                end else begin
                    // The incrementer input comes from the same mux, so the
                    // first advance computes 0+1 rather than stale+1.
                    way_d    = 1'b0;
                    set_d    = set_q + 5'd1;
                    incr_en  = 1'b1;
                    incr_mux = ~first_q;
                    first_d  = 1'b0;
                    state_d  = CHECK;
                end
            end

            DRAIN: begin
                if (bus.batch_send_istream_rdy && (acks_q == 11'd0)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                resp_val = 1'b1;
                if (bus.flush_resp_rdy) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.flush_req_rdy          = req_rdy;
    assign bus.flush_resp_val         = resp_val;
    assign bus.flush_busy             = (state_q != IDLE);
    // wb is cleared only when the next flush is accepted, so it doubles as
    // the "lines written by the last flush" report.
    assign bus.flush_wb_count         = wb_q;
    assign bus.index_mux_sel          = idx_mux;
    assign bus.idx_incr_mux_sel       = incr_mux;
    assign bus.index_incr_reg_en      = incr_en;
    assign bus.read_way               = way_out;
    assign bus.dirty_wen              = wen;
    assign bus.dirty_wdata            = 1'b0;
    assign bus.batch_send_istream_val = send_val;
    assign bus.batch_send_rw          = (state_q != IDLE);
    assign bus.batch_send_addr_sel    = (state_q != IDLE);

endmodule

// File: tb/tb_lab3_cache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lab3_cache_flush_ctrl
//
// Bench for the flush sequencer. Surrounds the DUT with a dirty-bit array,
// a datapath index register, a batch sender with programmable stalls and a
// memory that returns 16 write acks per sent line at random spacing.
// Expected send lists, write-back counts and completion cycles are derived
// from the dirty-array snapshot, the stall plan and the ack timing.
// ---------------------------------------------------------------------------
module tb_lab3_cache_flush_ctrl;

    logic clk = 1'b0;
    logic reset;

    lab3_cache_flush_ctrl_if bif ();

    lab3_cache_flush_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] RST_VEC = 19'h40000;

    // environment state
    logic       dirty_arr [64];          // index {way, set}
    logic [4:0] idx_reg;
    logic [4:0] cur_index;
    assign cur_index    = bif.idx_incr_mux_sel ? idx_reg : 5'd0;
    assign bif.is_dirty = dirty_arr[{bif.read_way, cur_index}];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    int   pending     = 0;
    int   stall_left  = 0;
    logic in_send     = 1'b0;
    int   ack_mode    = 0;               // 0 random, 1 first ack on a send fire
    logic stray_ack   = 1'b0;
    int   la          = -1000;           // cycle of last counted ack
    int   stall_plan[$];

    // monitor results
    int         n_chk_state, n_fire, n_wen, first_val_len, cur_val_len;
    int         stab_viol, ctl_viol, first_chk_cyc;
    logic [5:0] first_chk_pos;
    logic [5:0] send_log[$];
    logic       prev_val, prev_fire, fire_now;
    logic [5:0] prev_pos, pos;

    logic       upd_wen, upd_data, upd_incr;
    logic [5:0] upd_pos;
    logic [4:0] upd_next_idx;

    function automatic logic [18:0] out_vec();
        return {bif.flush_req_rdy, bif.flush_resp_val, bif.flush_busy,
                bif.flush_wb_count, bif.index_mux_sel, bif.idx_incr_mux_sel,
                bif.index_incr_reg_en, bif.read_way, bif.dirty_wen,
                bif.dirty_wdata, bif.batch_send_istream_val,
                bif.batch_send_rw, bif.batch_send_addr_sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Commit datapath-side effects just after the clock edge they belong to.
    initial begin
        upd_wen  = 1'b0;
        upd_incr = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!reset) begin
                if (upd_wen)  dirty_arr[upd_pos] = upd_data;
                if (upd_incr) idx_reg = upd_next_idx;
            end
            upd_wen  = 1'b0;
            upd_incr = 1'b0;
        end
    end

    // Sender / memory drive on the falling edge, then observe the outputs.
    initial begin
        bif.batch_send_istream_rdy = 1'b1;
        bif.mem_wr_ack             = 1'b0;
        prev_val  = 1'b0;
        prev_fire = 1'b0;
        prev_pos  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bif.batch_send_istream_rdy = 1'b1;
                bif.mem_wr_ack             = 1'b0;
                continue;
            end
            if (bif.batch_send_istream_val) begin
                if (!in_send) begin
                    in_send    = 1'b1;
                    stall_left = (stall_plan.size() > 0) ? stall_plan.pop_front() : 0;
                end
                if (stall_left > 0) begin
                    bif.batch_send_istream_rdy = 1'b0;
                    stall_left--;
                end else begin
                    bif.batch_send_istream_rdy = 1'b1;
                    in_send = 1'b0;
                end
            end else begin
                bif.batch_send_istream_rdy = 1'b1;
            end
            fire_now = bif.batch_send_istream_val && bif.batch_send_istream_rdy;

            bif.mem_wr_ack = 1'b0;
            if (stray_ack) begin
                bif.mem_wr_ack = 1'b1;
                stray_ack = 1'b0;
            end else if (pending > 0) begin
                if (ack_mode == 0) begin
                    bif.mem_wr_ack = ($urandom_range(0, 3) != 0);
                end else if (fire_now) begin
                    bif.mem_wr_ack = 1'b1;
                    ack_mode = 0;
                end
            end
            if (bif.mem_wr_ack && pending > 0) begin
                pending--;
                la = cyc - acc_cyc;
            end

            #1;
            if (bif.flush_req_rdy && bif.flush_busy) ctl_viol++;
            if (bif.batch_send_rw !== bif.flush_busy || bif.batch_send_addr_sel !== bif.flush_busy
                || bif.dirty_wdata !== 1'b0) ctl_viol++;
            pos = {bif.read_way, cur_index};
            if (bif.index_mux_sel && !bif.batch_send_istream_val) begin
                if (n_chk_state == 0) begin
                    first_chk_pos = pos;
                    first_chk_cyc = cyc - acc_cyc;
                end
                n_chk_state++;
            end
            if (bif.batch_send_istream_val) begin
                cur_val_len++;
                if (prev_val && !prev_fire && pos !== prev_pos) stab_viol++;
            end
            if (fire_now) begin
                n_fire++;
                send_log.push_back(pos);
                pending += 16;
                if (first_val_len == 0) first_val_len = cur_val_len;
                cur_val_len = 0;
            end
            if (bif.dirty_wen) begin
                n_wen++;
                upd_wen  = 1'b1;
                upd_pos  = pos;
                upd_data = bif.dirty_wdata;
            end
            upd_incr     = bif.index_incr_reg_en;
            upd_next_idx = cur_index + 5'd1;
            prev_val  = bif.batch_send_istream_val;
            prev_fire = fire_now;
            prev_pos  = pos;
        end
    end

    task automatic start_flush(input string tag);
        int ok = 0;
        n_chk_state = 0; n_fire = 0; n_wen = 0; first_val_len = 0; cur_val_len = 0;
        stab_viol = 0; ctl_viol = 0; first_chk_cyc = -1; first_chk_pos = '1;
        send_log.delete();
        la = -1000;
        @(negedge clk);
        bif.flush_req_val = 1'b1;
        #2;
        for (int i = 0; i < 8 && ok == 0; i++) begin
            if (bif.flush_req_rdy) begin
                ok = 1;
                acc_cyc = cyc;
            end else begin
                @(negedge clk);
                #2;
            end
        end
        check({tag, " accept"}, 32'(ok), 32'd1);
        @(negedge clk);
        bif.flush_req_val = 1'b0;
    endtask

    task automatic run_flush(input string tag, input int hold, input int exp_first_len);
        logic [5:0] exp_q[$];
        int stall_sum = 0;
        int got = 0;
        int resp_cyc = -1;
        int td, exp_resp, left;
        for (int s = 0; s < 32; s++)
            for (int w = 0; w < 2; w++)
                if (dirty_arr[{w[0], s[4:0]}]) exp_q.push_back({w[0], s[4:0]});
        foreach (stall_plan[i]) stall_sum += stall_plan[i];

        start_flush(tag);
        for (int i = 0; i < 5000 && got == 0; i++) begin
            @(negedge clk);
            #2;
            if (bif.flush_resp_val) begin
                got = 1;
                resp_cyc = cyc - acc_cyc;
            end
        end
        check({tag, " completes"}, 32'(got), 32'd1);

        // walk costs 2 cycles per line, +1 per dirty line, +stalls; then drain
        td = 1 + 128 + exp_q.size() + stall_sum;
        exp_resp = ((td > la + 1) ? td : la + 1) + 1;
        check({tag, " resp cycle"}, 32'(resp_cyc), 32'(exp_resp));

        for (int h = 0; h < hold; h++) begin
            check({tag, " resp held"}, 32'(bif.flush_resp_val), 32'd1);
            check({tag, " req_rdy low in DONE"}, 32'(bif.flush_req_rdy), 32'd0);
            @(negedge clk);
            #2;
        end
        check({tag, " resp_val"}, 32'(bif.flush_resp_val), 32'd1);
        check({tag, " wb_count"}, 32'(bif.flush_wb_count), 32'(exp_q.size()));
        bif.flush_resp_rdy = 1'b1;
        @(negedge clk);
        bif.flush_resp_rdy = 1'b0;
        #2;
        check({tag, " idle after resp"}, 32'({bif.flush_req_rdy, bif.flush_busy, bif.flush_resp_val}), 32'b100);
        check({tag, " wb_count held"}, 32'(bif.flush_wb_count), 32'(exp_q.size()));

        check({tag, " fires"}, 32'(n_fire), 32'(exp_q.size()));
        check({tag, " dirty_wen"}, 32'(n_wen), 32'(exp_q.size()));
        check({tag, " send count"}, 32'(send_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < send_log.size(); i++)
            check({tag, " send line"}, 32'(send_log[i]), 32'(exp_q[i]));
        check({tag, " checks"}, 32'(n_chk_state), 32'd64);
        check({tag, " first check line"}, 32'(first_chk_pos), 32'd0);
        check({tag, " first check cycle"}, 32'(first_chk_cyc), 32'd1);
        check({tag, " ctl outputs"}, 32'(ctl_viol), 32'd0);
        check({tag, " stall stability"}, 32'(stab_viol), 32'd0);
        if (exp_first_len > 0)
            check({tag, " first val length"}, 32'(first_val_len), 32'(exp_first_len));
        left = 0;
        for (int i = 0; i < 64; i++) if (dirty_arr[i]) left++;
        check({tag, " dirty left"}, 32'(left), 32'd0);
    endtask

    task automatic clear_dirty();
        for (int i = 0; i < 64; i++) dirty_arr[i] = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int left;
        reset              = 1'b1;
        bif.flush_req_val  = 1'b0;
        bif.flush_resp_rdy = 1'b0;
        idx_reg            = 5'd7;
        clear_dirty();

        repeat (3) @(negedge clk);
        #2;
        check("reset outputs", 32'(out_vec()), 32'(RST_VEC));
        reset = 1'b0;
        @(negedge clk);
        #2;
        check("post-reset outputs", 32'(out_vec()), 32'(RST_VEC));

        // clean cache, with a stray ack while idle
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        run_flush("clean", 0, 0);

        // two dirty lines, sender always ready
        clear_dirty();
        dirty_arr[{1'b1, 5'd0}]  = 1'b1;
        dirty_arr[{1'b0, 5'd31}] = 1'b1;
        run_flush("two", 0, 0);

        // sender stalls 5 cycles on the first dirty line
        clear_dirty();
        dirty_arr[{1'b0, 5'd2}]  = 1'b1;
        dirty_arr[{1'b1, 5'd7}]  = 1'b1;
        dirty_arr[{1'b1, 5'd30}] = 1'b1;
        stall_plan.push_back(5);
        run_flush("stall", 0, 6);

        // ack coincident with the second fire while 16 are outstanding
        clear_dirty();
        dirty_arr[{1'b0, 5'd0}] = 1'b1;
        dirty_arr[{1'b1, 5'd0}] = 1'b1;
        ack_mode = 1;
        run_flush("coincident", 0, 0);

        // random dirty pattern and stalls, completion held for 4 cycles
        clear_dirty();
        for (int i = 0; i < 64; i++) dirty_arr[i] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 64; i++) if (dirty_arr[i]) stall_plan.push_back(int'($urandom_range(0, 3)));
        run_flush("random", 4, 0);

        // reset in the middle of the walk, then a fresh flush
        clear_dirty();
        dirty_arr[{1'b0, 5'd3}]  = 1'b1;
        dirty_arr[{1'b1, 5'd5}]  = 1'b1;
        dirty_arr[{1'b0, 5'd20}] = 1'b1;
        dirty_arr[{1'b1, 5'd25}] = 1'b1;
        start_flush("abort");
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge clk);
            #2;
            if (bif.index_mux_sel && !bif.batch_send_istream_val && cur_index == 5'd10) found = 1;
        end
        check("abort reached set 10", 32'(found), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async reset outputs", 32'(out_vec()), 32'(RST_VEC));
        @(negedge clk);
        pending    = 0;
        in_send    = 1'b0;
        stall_left = 0;
        stall_plan.delete();
        #3;
        reset = 1'b0;
        left = 0;
        for (int i = 0; i < 64; i++) if (dirty_arr[i]) left++;
        check("cleared bits stay cleared", 32'(left), 32'd2);
        run_flush("restart", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
